gol_grid_engine: RTL and testbench

- Parametrised successor of the fixed 7x7 Game of Life top level.
- Merges control FSM and generation datapath onto one clock.
- Generalises grid size and edge topology (dead border or toroidal).
- Adds programmable step rate, single-step while paused, a cursor-based programming mode, a generation counter, and still-life/extinction detection with optional auto-pause.

---
 rtl/gol_grid_engine.sv | 184 ++++++++++++++++++
 tb/tb_gol_grid_engine.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gol_grid_engine.sv
// Purpose: parametrised Game of Life grid with control FSM, cursor programming and still/extinct detection.
// Latency: button events act 2 edges after the press is sampled; a new generation shows on out_grid the cycle after it fires.
// Backpressure: none; buttons are edge events and a held button yields a single event.
module gol_grid_engine #(
  parameter int ROWS          = 7,
  parameter int COLS          = 7,
  parameter int WRAP          = 0,
  parameter int PERIOD        = 4,
  parameter int GEN_W         = 16,
  parameter int HALT_ON_STILL = 1
) (
  input  logic                           in_clka,
  input  logic                           in_rst_n,
  input  logic                           in_stop,
  input  logic                           in_prgm,
  input  logic                           in_pp,
  input  logic                           in_btn0,
  input  logic                           in_btn1,
  output logic [1:0]                     out_game_state,
  output logic [ROWS*COLS-1:0]           out_grid,
  output logic [$clog2(ROWS*COLS)-1:0]   out_cursor,
  output logic [GEN_W-1:0]               out_gen_count,
  output logic                           out_still,
  output logic                           out_extinct
);

  localparam int N  = ROWS * COLS;
  localparam int CW = $clog2(N);
  localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PROGRAM = 2'd1,
    RUN     = 2'd2,
    PAUSE   = 2'd3
  } state_t;

  state_t          state;
  logic [N-1:0]    grid;
  logic [N-1:0]    next_grid;
  logic [CW-1:0]   cursor;
  logic [GEN_W-1:0] gen_count;
  logic            still;
  logic [TW-1:0]   tick;

  // Bit order {btn1, btn0, pp, prgm}
  logic [3:0] btn_s;
  logic [3:0] btn_p;
  logic [3:0] ev;
  logic       ev_prgm, ev_pp, ev_btn0, ev_btn1;

  always_ff @(posedge in_clka) begin
    if (!in_rst_n) begin
      btn_s <= '0;
      btn_p <= '0;
    end else begin
      btn_s <= {in_btn1, in_btn0, in_pp, in_prgm};
      btn_p <= btn_s;
    end
  end

  assign ev      = btn_s & ~btn_p;
  assign ev_prgm = ev[0];
  assign ev_pp   = ev[1];
  assign ev_btn0 = ev[2];
  assign ev_btn1 = ev[3];

  // Neighbour taps are resolved at elaboration; off-grid taps in dead-border mode tie to 0.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [7:0] nb;
      logic [3:0] ncnt;
      for (genvar k = 0; k < 8; k++) begin : g_nb
        localparam int DR  = (k < 3) ? -1 : ((k < 5) ? 0 : 1);
        localparam int DC  = (k < 3) ? (k - 1) : ((k == 3) ? -1 : ((k == 4) ? 1 : (k - 6)));
        localparam int RR  = r + DR;
        localparam int CC  = c + DC;
        localparam int RWR = (RR + ROWS) % ROWS;
        localparam int CWR = (CC + COLS) % COLS;
        localparam bit INB = (RR >= 0) && (RR < ROWS) && (CC >= 0) && (CC < COLS);
        localparam bit VAL = (WRAP != 0) || INB;
        localparam int SRC = (WRAP != 0) ? (RWR * COLS + CWR) : (INB ? (RR * COLS + CC) : 0);
        if (VAL) begin : g_tap
          assign nb[k] = grid[SRC];
        end else begin : g_dead
          assign nb[k] = 1'b0;
        end
      end
      assign ncnt = 4'($countones(nb));
      assign next_grid[r*COLS+c] = (ncnt == 4'd3) | (grid[r*COLS+c] & (ncnt == 4'd2));
    end
  end

  logic          tick_hit;
  logic          unchanged;
  logic          do_gen;
  logic [N-1:0]  cell_mask;
  logic [CW-1:0] cursor_inc;

  assign tick_hit   = (tick == TW'(PERIOD - 1));
  assign unchanged  = (next_grid == grid);
  assign cell_mask  = {{(N-1){1'b0}}, 1'b1} << cursor;
  assign cursor_inc = (cursor == CW'(N - 1)) ? '0 : cursor + 1'b1;

  // A generation fires only when no higher-priority event moves the state this cycle.
  always_comb begin
    do_gen = 1'b0;
    if (!ev_prgm && !ev_pp) begin
      if (state == RUN)   do_gen = tick_hit;
      if (state == PAUSE) do_gen = ev_btn1;
    end
  end

  always_ff @(posedge in_clka) begin
    if (!in_rst_n) begin
      state     <= IDLE;
      grid      <= '0;
      cursor    <= '0;
      gen_count <= '0;
      still     <= 1'b0;
      tick      <= '0;
    end else if (in_stop) begin
      state     <= IDLE;
      grid      <= '0;
      cursor    <= '0;
      gen_count <= '0;
      still     <= 1'b0;
      tick      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ev_prgm) begin
            state <= PROGRAM;
            still <= 1'b0;
          end
        end
        PROGRAM: begin
          if (ev_pp) begin
            state <= RUN;
            tick  <= '0;
          end else begin
            if (ev_btn0) grid   <= grid ^ cell_mask;
            if (ev_btn1) cursor <= cursor_inc;
          end
        end
        RUN: begin
          if (ev_prgm) begin
            state <= PROGRAM;
            still <= 1'b0;
          end else if (ev_pp) begin
            state <= PAUSE;
          end else begin
            tick <= tick_hit ? '0 : tick + 1'b1;
            if (tick_hit && (HALT_ON_STILL != 0) && unchanged) state <= PAUSE;
          end
        end
        PAUSE: begin
          if (ev_prgm) begin
            state <= PROGRAM;
            still <= 1'b0;
          end else if (ev_pp) begin
            state <= RUN;
            tick  <= '0;
          end
        end
        default: state <= IDLE;
      endcase

      if (do_gen) begin
        grid  <= next_grid;
        still <= unchanged;
        if (gen_count != {GEN_W{1'b1}}) gen_count <= gen_count + 1'b1;
      end
    end
  end

  assign out_game_state = state;
  assign out_grid       = grid;
  assign out_cursor     = cursor;
  assign out_gen_count  = gen_count;
  assign out_still      = still;
  assign out_extinct    = ~|grid;

endmodule

// File: tb/tb_gol_grid_engine.sv
// Bench for gol_grid_engine: three configurations driven by button tasks, generations scored against a queue of model grids.
module tb_gol_grid_engine;

  localparam int B_PRGM = 0;
  localparam int B_PP   = 1;
  localparam int B_0    = 2;
  localparam int B_1    = 3;
  localparam int B_STOP = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] stop = '0, prgm = '0, pp = '0, btn0 = '0, btn1 = '0;

  logic [1:0]  st_a, st_b, st_c;
  logic [48:0] grid_a;
  logic [24:0] grid_b, grid_c;
  logic [5:0]  cur_a;
  logic [4:0]  cur_b, cur_c;
  logic [15:0] gen_a, gen_b;
  logic [1:0]  gen_c;
  logic [2:0]  still, ext;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  gol_grid_engine #(.ROWS(7), .COLS(7), .WRAP(0), .PERIOD(4), .GEN_W(16), .HALT_ON_STILL(1)) dut_a (
    .in_clka(clk), .in_rst_n(rst_n), .in_stop(stop[0]), .in_prgm(prgm[0]), .in_pp(pp[0]),
    .in_btn0(btn0[0]), .in_btn1(btn1[0]), .out_game_state(st_a), .out_grid(grid_a),
    .out_cursor(cur_a), .out_gen_count(gen_a), .out_still(still[0]), .out_extinct(ext[0]));

  gol_grid_engine #(.ROWS(5), .COLS(5), .WRAP(1), .PERIOD(1), .GEN_W(16), .HALT_ON_STILL(0)) dut_b (
    .in_clka(clk), .in_rst_n(rst_n), .in_stop(stop[1]), .in_prgm(prgm[1]), .in_pp(pp[1]),
    .in_btn0(btn0[1]), .in_btn1(btn1[1]), .out_game_state(st_b), .out_grid(grid_b),
    .out_cursor(cur_b), .out_gen_count(gen_b), .out_still(still[1]), .out_extinct(ext[1]));

  gol_grid_engine #(.ROWS(5), .COLS(5), .WRAP(0), .PERIOD(16), .GEN_W(2), .HALT_ON_STILL(0)) dut_c (
    .in_clka(clk), .in_rst_n(rst_n), .in_stop(stop[2]), .in_prgm(prgm[2]), .in_pp(pp[2]),
    .in_btn0(btn0[2]), .in_btn1(btn1[2]), .out_game_state(st_c), .out_grid(grid_c),
    .out_cursor(cur_c), .out_gen_count(gen_c), .out_still(still[2]), .out_extinct(ext[2]));

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] grid_of(input int i);
    case (i)
      0:       return 64'(grid_a);
      1:       return 64'(grid_b);
      default: return 64'(grid_c);
    endcase
  endfunction

  function automatic logic [63:0] st_of(input int i);
    case (i)
      0:       return 64'(st_a);
      1:       return 64'(st_b);
      default: return 64'(st_c);
    endcase
  endfunction

  function automatic logic [63:0] cur_of(input int i);
    case (i)
      0:       return 64'(cur_a);
      1:       return 64'(cur_b);
      default: return 64'(cur_c);
    endcase
  endfunction

  function automatic logic [63:0] gen_of(input int i);
    case (i)
      0:       return 64'(gen_a);
      1:       return 64'(gen_b);
      default: return 64'(gen_c);
    endcase
  endfunction

  // Reference B3/S23 step on a rows x cols grid packed row-major.
  function automatic logic [63:0] life(input logic [63:0] g, input int rows, input int cols, input bit wrap);
    logic [63:0] n;
    int cnt, rr, cc;
    n = '0;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) begin
              rr = r + dr;
              cc = c + dc;
              if (wrap) begin
                rr = (rr + rows) % rows;
                cc = (cc + cols) % cols;
              end
              if (rr >= 0 && rr < rows && cc >= 0 && cc < cols && g[rr*cols+cc]) cnt++;
            end
          end
        end
        n[r*cols+c] = (cnt == 3) || (g[r*cols+c] && cnt == 2);
      end
    end
    return n;
  endfunction

  task automatic set_btn(input int i, input int b, input logic v);
    case (b)
      B_PRGM:  prgm[i] = v;
      B_PP:    pp[i]   = v;
      B_0:     btn0[i] = v;
      B_1:     btn1[i] = v;
      default: stop[i] = v;
    endcase
  endtask

  task automatic press(input int i, input int b);
    @(negedge clk);
    set_btn(i, b, 1'b1);
    repeat (2) @(negedge clk);
    set_btn(i, b, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  task automatic set_cell(input int i, input int idx);
    int guard = 0;
    while (cur_of(i) != 64'(idx) && guard < 64) begin
      press(i, B_1);
      guard++;
    end
    check_eq("cursor_reach", cur_of(i), 64'(idx));
    press(i, B_0);
  endtask

  // Waits for the generation counter to reach target, then scores the grid against the queue head.
  task automatic wait_gen(input int i, input int target, output int cyc);
    cyc = 0;
    while (gen_of(i) != 64'(target) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("gen_reach", gen_of(i), 64'(target));
    if (exp_q.size() > 0) check_eq("sb_grid", grid_of(i), exp_q.pop_front());
    else check_eq("sb_empty", 64'(exp_q.size()), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] g0, g, blink_h, blink_v, block;
    int cyc, w;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_eq("rst_state", st_of(0), 64'd0);
    check_eq("rst_grid", grid_of(0), 64'd0);
    check_eq("rst_cursor", cur_of(0), 64'd0);
    check_eq("rst_gen", gen_of(0), 64'd0);
    check_eq("rst_still", 64'(still[0]), 64'd0);
    check_eq("rst_extinct", 64'(ext[0]), 64'd1);
    check_eq("rst_state_b", st_of(1), 64'd0);
    check_eq("rst_state_c", st_of(2), 64'd0);

    // Cursor programming
    press(0, B_PRGM);
    repeat (3) press(0, B_1);
    press(0, B_0);
    check_eq("prog_state", st_of(0), 64'd1);
    check_eq("prog_cursor", cur_of(0), 64'd3);
    check_eq("prog_grid", grid_of(0), 64'h8);
    check_eq("prog_extinct", 64'(ext[0]), 64'd0);

    // Blinker, dead border, PERIOD=4
    blink_h = (64'd1 << 23) | (64'd1 << 24) | (64'd1 << 25);
    blink_v = (64'd1 << 17) | (64'd1 << 24) | (64'd1 << 31);
    press(0, B_STOP);
    check_eq("stop_cursor", cur_of(0), 64'd0);
    press(0, B_PRGM);
    set_cell(0, 23);
    set_cell(0, 24);
    set_cell(0, 25);
    check_eq("blink_prog", grid_of(0), blink_h);
    exp_q.push_back(life(blink_h, 7, 7, 1'b0));
    exp_q.push_back(life(life(blink_h, 7, 7, 1'b0), 7, 7, 1'b0));
    @(negedge clk);
    pp[0] = 1'b1;
    w = 0;
    while (st_of(0) != 64'd2 && w < 10) begin
      @(negedge clk);
      w++;
    end
    pp[0] = 1'b0;
    check_eq("run_entry", st_of(0), 64'd2);
    wait_gen(0, 1, cyc);
    check_eq("first_gen_latency", 64'(cyc), 64'd4);
    check_eq("blink_vert", grid_of(0), blink_v);
    wait_gen(0, 2, cyc);
    check_eq("second_gen_latency", 64'(cyc), 64'd4);
    check_eq("blink_horiz", grid_of(0), blink_h);
    check_eq("blink_still", 64'(still[0]), 64'd0);
    press(0, B_PP);
    check_eq("pause_state", st_of(0), 64'd3);
    check_eq("pause_gen", gen_of(0), 64'd2);

    // Block halts on still life; single step in PAUSE
    block = (64'd1 << 16) | (64'd1 << 17) | (64'd1 << 23) | (64'd1 << 24);
    press(0, B_STOP);
    press(0, B_PRGM);
    set_cell(0, 16);
    set_cell(0, 17);
    set_cell(0, 23);
    set_cell(0, 24);
    exp_q.push_back(life(block, 7, 7, 1'b0));
    press(0, B_PP);
    wait_gen(0, 1, cyc);
    check_eq("halt_still", 64'(still[0]), 64'd1);
    check_eq("halt_state", st_of(0), 64'd3);
    exp_q.push_back(life(block, 7, 7, 1'b0));
    press(0, B_1);
    wait_gen(0, 2, cyc);
    check_eq("step_block", grid_of(0), block);
    check_eq("step_state", st_of(0), 64'd3);

    // Glider on 5x5 torus, one generation per cycle
    g0 = (64'd1 << 1) | (64'd1 << 7) | (64'd1 << 10) | (64'd1 << 11) | (64'd1 << 12);
    press(1, B_PRGM);
    set_cell(1, 1);
    set_cell(1, 7);
    set_cell(1, 10);
    set_cell(1, 11);
    set_cell(1, 12);
    check_eq("glider_prog", grid_of(1), g0);
    g = g0;
    for (int k = 0; k < 20; k++) begin
      g = life(g, 5, 5, 1'b1);
      exp_q.push_back(g);
    end
    @(negedge clk);
    pp[1] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      wait_gen(1, k, cyc);
      if (k == 2) check_eq("period1_rate", 64'(cyc), 64'd1);
    end
    check_eq("glider_return", grid_of(1), g0);
    check_eq("glider_gen", gen_of(1), 64'd20);
    pp[1] = 1'b0;

    // Single cell in PAUSE dies on step; stop clears
    press(2, B_PRGM);
    set_cell(2, 12);
    press(2, B_PP);
    press(2, B_PP);
    check_eq("c_pause", st_of(2), 64'd3);
    check_eq("c_pause_gen", gen_of(2), 64'd0);
    exp_q.push_back(life(64'd1 << 12, 5, 5, 1'b0));
    press(2, B_1);
    wait_gen(2, 1, cyc);
    check_eq("single_dead", grid_of(2), 64'd0);
    check_eq("single_extinct", 64'(ext[2]), 64'd1);
    press(2, B_STOP);
    check_eq("stop_state", st_of(2), 64'd0);
    check_eq("stop_cursor_c", cur_of(2), 64'd0);
    check_eq("stop_gen", gen_of(2), 64'd0);

    // GEN_W=2 saturation over five generations
    press(2, B_PRGM);
    set_cell(2, 11);
    set_cell(2, 12);
    set_cell(2, 13);
    press(2, B_PP);
    repeat (84) @(negedge clk);
    check_eq("sat_gen", gen_of(2), 64'd3);
    check_eq("sat_grid", grid_of(2), (64'd1 << 7) | (64'd1 << 12) | (64'd1 << 17));
    check_eq("sat_state", st_of(2), 64'd2);

    // prgm outranks pp in the same cycle
    @(negedge clk);
    prgm[2] = 1'b1;
    pp[2]   = 1'b1;
    repeat (2) @(negedge clk);
    prgm[2] = 1'b0;
    pp[2]   = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("prgm_over_pp", st_of(2), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
